mem_stage_lsu: RTL and testbench

Parametrised memory stage for the RISC-V pipeline, placed between execute and writeback. It performs byte, halfword and word loads and stores with sign or zero extension against an internal data memory with configurable access latency. It stalls upstream while an access is in flight and flags misaligned or illegal accesses. It registers the writeback triple (data, address, enable) and the bypass value for forwarding.

---
 rtl/mem_stage_lsu.sv | 171 +++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// Memory stage: byte/half/word loads and stores against an internal data memory
// with a fixed access latency, plus registered writeback and forwarding outputs.
module mem_stage_lsu #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int MEM_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [XLEN-1:0] alu_out,
  input  logic [4:0]      rd,
  input  logic            reg_we,
  input  logic            mem_re,
  input  logic            mem_we,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] wd,
  output logic            stall,
  output logic [XLEN-1:0] wb_d,
  output logic [4:0]      wb_a,
  output logic            wb_we,
  output logic [XLEN-1:0] bp_mem,
  output logic            mem_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int NB = XLEN / 8;
  localparam bit HAS_WAIT = (MEM_LATENCY > 0);
  localparam logic [3:0] CNT_INIT = 4'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              stall_next, mem_done;
  logic              mem_op, size_ok, misaligned, err, mem_go;
  logic [AW-1:0]     idx;
  logic [NB-1:0]     byte_en;
  logic [XLEN-1:0]   st_data;
  logic [XLEN-1:0]   mem [DEPTH_WORDS];
  logic [XLEN-1:0]   mem_q;
  logic [XLEN-1:0]   ld_word, ld_ext;

  logic [XLEN-1:0]   wb_d_reg, bp_mem_reg;
  logic [4:0]        wb_a_reg;
  logic              wb_we_reg, mem_err_reg, load_sel_reg;
  logic [2:0]        f3_reg;
  logic [1:0]        lane_reg;

  assign idx    = alu_out[AW+1:2];
  assign mem_op = mem_re | mem_we;

  always_comb begin
    size_ok = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: size_ok = 1'b1;
      default: size_ok = 1'b0;
    endcase
  end

  assign misaligned = ((funct3[1:0] == 2'b01) & alu_out[0]) |
                      ((funct3[1:0] == 2'b10) & (|alu_out[1:0]));
  assign err    = valid_in & mem_op & (~size_ok | (mem_re & mem_we) | misaligned);
  assign mem_go = valid_in & mem_op & ~err;

  // Lane enables and lane-replicated store data, one byte lane per iteration.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign byte_en[gi] = (funct3[1:0] == 2'b10) |
                         ((funct3[1:0] == 2'b01) & (alu_out[1] == 1'(gi / 2))) |
                         ((funct3[1:0] == 2'b00) & (alu_out[1:0] == 2'(gi)));
    assign st_data[gi*8 +: 8] = (funct3[1:0] == 2'b10) ? wd[gi*8 +: 8] :
                                (funct3[1:0] == 2'b01) ? wd[(gi%2)*8 +: 8] : wd[7:0];
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall_next = 1'b0;
    mem_done   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_go) begin
          if (HAS_WAIT) begin
            state_next = BUSY;
            cnt_next   = CNT_INIT;
            stall_next = 1'b1;
          end else begin
            mem_done = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cnt_reg != 4'd0) begin
          cnt_next   = cnt_reg - 4'd1;
          stall_next = 1'b1;
        end else begin
          mem_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Inputs may still present a memory op while reset is held; keep stall quiet then.
  assign stall = stall_next & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Data array is not reset; writes and reads happen only at the completing edge.
  always_ff @(posedge clk) begin
    if (mem_done & mem_we & rst) begin
      for (int i = 0; i < NB; i++) begin
        if (byte_en[i]) mem[idx][i*8 +: 8] <= st_data[i*8 +: 8];
      end
    end
    if (mem_done & mem_re & rst) mem_q <= mem[idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_d_reg     <= '0;
      wb_a_reg     <= 5'd0;
      wb_we_reg    <= 1'b0;
      bp_mem_reg   <= '0;
      mem_err_reg  <= 1'b0;
      load_sel_reg <= 1'b0;
      f3_reg       <= 3'd0;
      lane_reg     <= 2'd0;
    end else if (stall | ~valid_in) begin
      wb_we_reg   <= 1'b0;
      mem_err_reg <= 1'b0;
    end else begin
      wb_we_reg    <= reg_we & (rd != 5'd0) & ~err & ~mem_we;
      mem_err_reg  <= err;
      wb_a_reg     <= rd;
      bp_mem_reg   <= alu_out;
      wb_d_reg     <= alu_out;
      load_sel_reg <= mem_re & ~err;
      f3_reg       <= funct3;
      lane_reg     <= alu_out[1:0];
    end
  end

  // Shifting by the lane offset also aligns halves, since they are 2-byte aligned.
  always_comb begin
    ld_word = mem_q >> {lane_reg, 3'b000};
    case (f3_reg)
      3'b000:  ld_ext = {{(XLEN-8){ld_word[7]}}, ld_word[7:0]};
      3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_word[7:0]};
      3'b001:  ld_ext = {{(XLEN-16){ld_word[15]}}, ld_word[15:0]};
      3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_word[15:0]};
      default: ld_ext = mem_q;
    endcase
  end

  assign wb_d    = load_sel_reg ? ld_ext : wb_d_reg;
  assign wb_a    = wb_a_reg;
  assign wb_we   = wb_we_reg;
  assign bp_mem  = bp_mem_reg;
  assign mem_err = mem_err_reg;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: byte-addressed reference model, per-cycle compare,
// directed literal checks and a randomized instruction stream.
module tb_mem_stage_lsu;

  localparam int LAT = 2;

  logic        clk, rst;
  logic        valid_in, reg_we, mem_re, mem_we;
  logic [31:0] alu_out, wd;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic        stall, wb_we, mem_err;
  logic [31:0] wb_d, bp_mem;
  logic [4:0]  wb_a;

  mem_stage_lsu #(.XLEN(32), .DEPTH_WORDS(1024), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .alu_out(alu_out), .rd(rd),
    .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we), .funct3(funct3), .wd(wd),
    .stall(stall), .wb_d(wb_d), .wb_a(wb_a), .wb_we(wb_we), .bp_mem(bp_mem),
    .mem_err(mem_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // Reference state: memory as 4096 bytes, plus expected registered outputs.
  logic [7:0]  mdl [4096];
  logic        exp_stall, exp_we, exp_err, d_known, check_en;
  logic [31:0] exp_d, exp_bp;
  logic [4:0]  exp_wa;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int size_of(input logic [2:0] f);
    case (f)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [2:0] f);
    int n = size_of(f);
    logic [31:0] v = 0;
    for (int k = 0; k < n; k++) v = v | (32'(mdl[12'(a[11:0] + k)]) << (8 * k));
    if ((f == 3'b000 || f == 3'b001) && v[8*n-1]) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("wb_we", 32'(wb_we), 32'(exp_we));
      chk("mem_err", 32'(mem_err), 32'(exp_err));
      chk("wb_a", 32'(wb_a), 32'(exp_wa));
      chk("bp_mem", bp_mem, exp_bp);
      if (d_known) chk("wb_d", wb_d, exp_d);
    end
  end

  // Present one instruction and hold it until the model says it is accepted.
  task automatic issue(input logic v, input logic re, input logic we, input logic rwe,
                       input logic [4:0] r, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d);
    int sz, n;
    logic e;
    valid_in = v; mem_re = re; mem_we = we; reg_we = rwe;
    rd = r; funct3 = f; alu_out = a; wd = d;
    sz = size_of(f);
    e  = v && (re || we) && (sz == 0 || (re && we) || (a % sz) != 0);
    n  = (v && (re || we) && !e) ? LAT : 0;
    for (int c = 0; c <= n; c++) begin
      exp_stall = (c < n);
      @(posedge clk);
      #1;
      exp_we  = 1'b0;
      exp_err = 1'b0;
      if (c == n && v) begin
        exp_err = e;
        exp_wa  = r;
        exp_bp  = a;
        exp_we  = rwe && (r != 0) && !e && !we;
        if (e) d_known = 1'b0;
        else if (re) begin exp_d = mdl_load(a, f); d_known = 1'b1; end
        else if (we) begin
          for (int k = 0; k < sz; k++) mdl[12'(a[11:0] + k)] = d[8*k +: 8];
          d_known = 1'b0;
        end else begin exp_d = a; d_known = 1'b1; end
      end
    end
    exp_stall = 1'b0;
  endtask

  task automatic idle();
    issue(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0);
  endtask

  initial begin
    logic [2:0] ld_f3 [5];
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    rst = 1'b0; valid_in = 0; mem_re = 0; mem_we = 0; reg_we = 0;
    rd = 0; funct3 = 0; alu_out = 0; wd = 0;
    exp_stall = 0; exp_we = 0; exp_err = 0; exp_d = 0; exp_bp = 0; exp_wa = 0;
    d_known = 1; check_en = 1;
    repeat (2) @(negedge clk);
    @(posedge clk); #3 rst = 1'b1;

    // Store/load round trip with latency 2
    issue(1, 0, 1, 0, 5'd0, 3'b010, 32'h10, 32'hDEADBEEF);
    issue(1, 1, 0, 1, 5'd5, 3'b010, 32'h10, 32'h0);
    chk("lw_data", wb_d, 32'hDEADBEEF);
    chk("lw_rd", 32'(wb_a), 32'd5);
    chk("lw_we", 32'(wb_we), 32'd1);

    // Lane extraction
    issue(1, 0, 1, 0, 5'd0, 3'b010, 32'h20, 32'h8081F0F1);
    issue(1, 1, 0, 1, 5'd1, 3'b000, 32'h23, 32'h0);
    chk("lb", wb_d, 32'hFFFFFF80);
    issue(1, 1, 0, 1, 5'd1, 3'b100, 32'h23, 32'h0);
    chk("lbu", wb_d, 32'h00000080);
    issue(1, 1, 0, 1, 5'd1, 3'b001, 32'h20, 32'h0);
    chk("lh", wb_d, 32'hFFFFF0F1);
    issue(1, 1, 0, 1, 5'd1, 3'b101, 32'h22, 32'h0);
    chk("lhu", wb_d, 32'h00008081);

    // Byte store merge
    issue(1, 0, 1, 0, 5'd0, 3'b010, 32'h20, 32'h11223344);
    issue(1, 0, 1, 0, 5'd0, 3'b000, 32'h21, 32'h000000AA);
    issue(1, 1, 0, 1, 5'd2, 3'b010, 32'h20, 32'h0);
    chk("sb_merge", wb_d, 32'h1122AA44);

    // Errors: misaligned LW, illegal funct3, re+we, misaligned store leaves memory alone
    issue(1, 0, 1, 0, 5'd0, 3'b010, 32'h04, 32'hCAFE0004);
    issue(1, 1, 0, 1, 5'd3, 3'b010, 32'h06, 32'h0);
    chk("mis_err", 32'(mem_err), 32'd1);
    chk("mis_we", 32'(wb_we), 32'd0);
    idle();
    chk("err_pulse_end", 32'(mem_err), 32'd0);
    issue(1, 1, 0, 1, 5'd3, 3'b011, 32'h08, 32'h0);
    chk("f3_err", 32'(mem_err), 32'd1);
    issue(1, 1, 1, 1, 5'd3, 3'b010, 32'h08, 32'h0);
    chk("rewe_err", 32'(mem_err), 32'd1);
    issue(1, 0, 1, 0, 5'd0, 3'b010, 32'h06, 32'hFFFFFFFF);
    issue(1, 1, 0, 1, 5'd4, 3'b010, 32'h04, 32'h0);
    chk("mem_unchanged", wb_d, 32'hCAFE0004);

    // rd=0, aliasing, ALU pass-through
    issue(1, 1, 0, 1, 5'd0, 3'b010, 32'h04, 32'h0);
    chk("rd0_we", 32'(wb_we), 32'd0);
    issue(1, 1, 0, 1, 5'd6, 3'b010, 32'h1004, 32'h0);
    chk("alias", wb_d, 32'hCAFE0004);
    issue(1, 0, 0, 1, 5'd7, 3'b000, 32'h1234, 32'h0);
    chk("alu_wb_d", wb_d, 32'h1234);
    chk("alu_bp", bp_mem, 32'h1234);
    chk("alu_we", 32'(wb_we), 32'd1);

    // Reset while a store is in flight
    issue(1, 0, 1, 0, 5'd0, 3'b010, 32'h30, 32'h0BADF00D);
    valid_in = 1; mem_re = 0; mem_we = 1; reg_we = 0; rd = 0;
    funct3 = 3'b010; alu_out = 32'h30; wd = 32'h55555555;
    exp_stall = 1;
    @(posedge clk); #1;
    exp_we = 0; exp_err = 0;
    #2 rst = 1'b0;
    exp_stall = 0; exp_d = 0; d_known = 1; exp_bp = 0; exp_wa = 0;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_wb_d", wb_d, 32'd0);
    @(posedge clk); #1;
    valid_in = 0; mem_we = 0;
    #1 rst = 1'b1;
    idle();
    issue(1, 1, 0, 1, 5'd9, 3'b010, 32'h30, 32'h0);
    chk("rst_abort", wb_d, 32'h0BADF00D);

    // Randomized stream over a pre-filled 64-word window, with aliasing high bits
    for (int w = 0; w < 64; w++)
      issue(1, 0, 1, 0, 5'd0, 3'b010, 32'(w * 4), $urandom);
    for (int i = 0; i < 300; i++) begin
      int kind = $urandom_range(0, 9);
      logic [31:0] a = 32'(($urandom_range(0, 15) << 12) | ($urandom_range(0, 63) << 2)
                           | $urandom_range(0, 3));
      logic [4:0] r = 5'($urandom_range(0, 31));
      logic rwe = 1'($urandom_range(0, 1));
      case (kind)
        0:       idle();
        1, 2:    issue(1, 0, 0, rwe, r, 3'($urandom_range(0, 7)), $urandom, 32'h0);
        3, 4, 5: issue(1, 1, 0, rwe, r, ld_f3[$urandom_range(0, 4)], a, 32'h0);
        6, 7, 8: issue(1, 0, 1, rwe, r, 3'($urandom_range(0, 2)), a, $urandom);
        default: issue(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rwe, r,
                       3'($urandom_range(0, 7)), a, $urandom);
      endcase
    end
    idle();
    check_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
